wb_bus_arbiter: RTL

//  Shares one Wishbone classic peripheral bus between two controllers: requester 0 is the
//  CPU instruction port (instr_wb) and requester 1 is the CPU data port (data_wb).

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_arb_picker.sv | 22 ++
 rtl/wb_bus_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone bus arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic OWNER0 = 1'b0;
  localparam logic OWNER1 = 1'b1;

  // Timeout counter width: wide enough for TIMEOUT_CYCLES, kept within 8..16 bits.
  function automatic int tmo_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// Combinational winner selection between two pending requests.
module wb_arb_picker
  import wb_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = req[1];
    // On contention round-robin favours whoever did not own last; fixed priority favours data.
    if (req == 2'b11) begin
      winner = (ROUND_ROBIN != 0) ? ~last_owner : OWNER1;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-controller Wishbone classic arbiter: instruction port (req0) and data port (req1) share one bus.
// Optional watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          req0_cyc,
  input  logic          req0_stb,
  input  logic          req0_we,
  input  logic [SW-1:0] req0_sel,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic          req0_err,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_cyc,
  input  logic          req1_stb,
  input  logic          req1_we,
  input  logic [SW-1:0] req1_sel,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic          req1_err,
  output logic [DW-1:0] req1_rdata,
  output logic          periph_cyc,
  output logic          periph_stb,
  output logic          periph_we,
  output logic [SW-1:0] periph_sel,
  output logic [AW-1:0] periph_addr,
  output logic [DW-1:0] periph_wdata,
  input  logic          periph_ack,
  input  logic          periph_err,
  input  logic [DW-1:0] periph_rdata,
  output logic [1:0]    o_grant,
  output logic          o_timeout,
  output arb_state_t    dbg_state
);

  // Handshake: a requester asks with cyc&stb; each beat completes when ack or err is seen
  // while it owns the bus; ownership lasts until the owner drops cyc.
  arb_state_t state;
  logic       last_owner;
  logic       pick_winner;
  logic       pick_valid;
  logic       tmo;

  wb_arb_picker #(.ROUND_ROBIN(ROUND_ROBIN)) u_picker (
    .req        ({req1_cyc & req1_stb, req0_cyc & req0_stb}),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int              CW       = tmo_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt;

  assign tmo = (state != ARB_IDLE) && (wait_cnt == TMO_LAST);

  // Held at zero while idle so every new ownership starts counting from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (state == ARB_IDLE || periph_ack || periph_err) begin
      wait_cnt <= '0;
    end else if (!tmo) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ARB_IDLE;
      last_owner <= OWNER1;
      o_grant    <= 2'b00;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state   <= pick_winner ? ARB_OWN1 : ARB_OWN0;
            o_grant <= pick_winner ? 2'b10 : 2'b01;
          end
        end
        ARB_OWN0: begin
          if (!req0_cyc || tmo) begin
            state      <= ARB_IDLE;
            last_owner <= OWNER0;
            o_grant    <= 2'b00;
          end
        end
        ARB_OWN1: begin
          if (!req1_cyc || tmo) begin
            state      <= ARB_IDLE;
            last_owner <= OWNER1;
            o_grant    <= 2'b00;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          o_grant <= 2'b00;
        end
      endcase
    end
  end

  assign o_timeout = tmo;
  assign dbg_state = state;

  always_comb begin
    periph_cyc   = 1'b0;
    periph_stb   = 1'b0;
    periph_we    = 1'b0;
    periph_sel   = '0;
    periph_addr  = '0;
    periph_wdata = '0;
    req0_ack     = 1'b0;
    req0_err     = 1'b0;
    req0_rdata   = '0;
    req1_ack     = 1'b0;
    req1_err     = 1'b0;
    req1_rdata   = '0;
    case (state)
      ARB_OWN0: begin
        periph_cyc   = req0_cyc & ~tmo;
        periph_stb   = req0_stb & ~tmo;
        periph_we    = req0_we;
        periph_sel   = req0_sel;
        periph_addr  = req0_addr;
        periph_wdata = req0_wdata;
        req0_ack     = periph_ack;
        req0_err     = periph_err | tmo;
        req0_rdata   = periph_rdata;
      end
      ARB_OWN1: begin
        periph_cyc   = req1_cyc & ~tmo;
        periph_stb   = req1_stb & ~tmo;
        periph_we    = req1_we;
        periph_sel   = req1_sel;
        periph_addr  = req1_addr;
        periph_wdata = req1_wdata;
        req1_ack     = periph_ack;
        req1_err     = periph_err | tmo;
        req1_rdata   = periph_rdata;
      end
      default: ;
    endcase
  end

endmodule
